// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the unified memory arbiter.
// The arbiter uses the slave modport; the core and memory environment use master.
interface mem_arbiter_if #(
  parameter int ADDR = 16,
  parameter int WORD = 32
);
  logic            if_req_i;
  logic [ADDR-1:0] if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [WORD-1:0] if_rdata_o;

  logic            d_req_i;
  logic            d_we_i;
  logic [ADDR-1:0] d_addr_i;
  logic [WORD-1:0] d_wdata_i;
  logic            d_gnt_o;
  logic            d_rvalid_o;
  logic [WORD-1:0] d_rdata_o;

  logic [ADDR-1:0] mem_a_o;
  logic            mem_w_o;
  logic [WORD-1:0] mem_d_o;
  logic [WORD-1:0] mem_q_i;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_q_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_a_o, mem_w_o, mem_d_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_q_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_a_o, mem_w_o, mem_d_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one registered-read memory port between fetch and data; data has priority.
// Define MEM_ARB_STARVE_EN to add a counter that forces a fetch grant after MAXWAIT refusals.
module mem_arbiter #(
  parameter int ADDR    = 16,
  parameter int WORD    = 32,
  parameter int MAXWAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RET} state_t;

  state_t          state_q;
  logic            rd_if_q;
  logic            rd_d_q;
  logic            force_if;
  logic            if_gnt;
  logic            d_gnt;
  logic            rd_start;
  logic [ADDR-1:0] mem_a;
  logic [WORD-1:0] rdata;

  if (MAXWAIT < 1 || MAXWAIT > 15) begin : g_maxwait_check
    $error("mem_arbiter: MAXWAIT must be in 1..15");
  end

  // Grants are gated by rst so nothing is accepted while reset is asserted.
  assign d_gnt    = rst & bus.d_req_i & ~(force_if & bus.if_req_i);
  assign if_gnt   = rst & bus.if_req_i & ~d_gnt;
  assign rd_start = if_gnt | (d_gnt & ~bus.d_we_i);

`ifdef MEM_ARB_STARVE_EN
  localparam logic [3:0] MAXWAIT_C = 4'(MAXWAIT);

  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;

  assign force_if = (wait_cnt_q == MAXWAIT_C);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.if_req_i || if_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAXWAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // RET may be re-entered directly, so back-to-back reads stream one per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rd_if_q <= 1'b0;
      rd_d_q  <= 1'b0;
    end else begin
      rd_if_q <= if_gnt;
      rd_d_q  <= d_gnt & ~bus.d_we_i;
      case (state_q)
        IDLE:    if (rd_start)  state_q <= RET;
        RET:     if (!rd_start) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_a = d_gnt ? bus.d_addr_i : bus.if_addr_i;
  assign rdata = bus.mem_q_i;

  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.mem_a_o     = mem_a;
  assign bus.mem_w_o     = d_gnt & bus.d_we_i;
  assign bus.mem_d_o     = bus.d_wdata_i;
  assign bus.if_rvalid_o = (state_q == RET) & rd_if_q;
  assign bus.d_rvalid_o  = (state_q == RET) & rd_d_q;
  assign bus.if_rdata_o  = rdata;
  assign bus.d_rdata_o   = rdata;

endmodule
